// File: rtl/synth_reg_pkg.sv
// synth_reg_pkg: shared types and constants for the synth parameter-register bus writer.
//   ADR_W / DATA_W  bus address and data widths
//   SEL_*           section indices (osc, env, matrix, common)
//   state_e         bus-cycle FSM states
//   req_t           queued update record {sel, adr, data}
package synth_reg_pkg;

  localparam int unsigned ADR_W  = 7;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned SEL_W  = 2;

  localparam int unsigned SEL_OSC = 0;
  localparam int unsigned SEL_ENV = 1;
  localparam int unsigned SEL_MAT = 2;
  localparam int unsigned SEL_COM = 3;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } state_e;

  typedef struct packed {
    logic [SEL_W-1:0]  sel;
    logic [ADR_W-1:0]  adr;
    logic [DATA_W-1:0] data;
  } req_t;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/synth_reg_writer_if.sv
// synth_reg_writer_if: request handshake plus parameter-register bus.
//   req_valid/req_ready/req_sel/req_adr/req_data  update requests from the control side
//   adr/data/write/sel                            bus towards osc/env/matrix receivers
// Modports: master = the bus writer, slave = the request source / bus observer.
interface synth_reg_writer_if #(
  parameter int unsigned N_SEL = 4
) ();
  import synth_reg_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [SEL_W-1:0]  req_sel;
  logic [ADR_W-1:0]  req_adr;
  logic [DATA_W-1:0] req_data;

  logic [ADR_W-1:0]  adr;
  logic [DATA_W-1:0] data;
  logic              write;
  logic [N_SEL-1:0]  sel;

  modport master (
    input  req_valid, req_sel, req_adr, req_data,
    output req_ready, adr, data, write, sel
  );

  modport slave (
    output req_valid, req_sel, req_adr, req_data,
    input  req_ready, adr, data, write, sel
  );

endinterface

// File: rtl/synth_reg_fifo.sv
// synth_reg_fifo: single-clock request queue, strictly FIFO order.
//   clk, rst_n      clock / async active-low reset (pointers and count only)
//   push, wdata     enqueue (ignored when full)
//   pop, rdata      dequeue; rdata always shows the head entry
//   full, empty     derived from the registered count
module synth_reg_fifo
  import synth_reg_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  req_t wdata,
  input  logic pop,
  output req_t rdata,
  output logic full,
  output logic empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  req_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  // Storage is not reset; entries are only read once count says they are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/synth_reg_writer.sv
// synth_reg_writer: bus master for the synth parameter-register bus.
// Queues update requests, then plays each one out as setup / strobe / hold so receivers that
// latch on the falling edge of write always see stable adr/data/sel.
//   OSC_CLK   block clock (posedge)
//   iRST_N    async active-low reset
//   bus       synth_reg_writer_if.master: request handshake in, bus adr/data/write/sel out
//   busy      queue non-empty or a bus cycle in progress
//   drop_cnt  saturating count of accepted requests with an out-of-range section index
// Optional build macro SYNTH_REG_SHADOW_EN adds a shadow RAM of everything written, read via
//   rd_sel/rd_adr -> rd_data (one cycle registered, contents not reset).
module synth_reg_writer
  import synth_reg_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned N_SEL      = 4,
  parameter int unsigned SETUP_CYC  = 2,
  parameter int unsigned STROBE_CYC = 2,
  parameter int unsigned HOLD_CYC   = 2
) (
  input  logic                       OSC_CLK,
  input  logic                       iRST_N,
  synth_reg_writer_if.master         bus,
  output logic                       busy,
  output logic [7:0]                 drop_cnt
`ifdef SYNTH_REG_SHADOW_EN
  ,
  input  logic [SEL_W-1:0]           rd_sel,
  input  logic [ADR_W-1:0]           rd_adr,
  output logic [DATA_W-1:0]          rd_data
`endif
);

  localparam int unsigned PH_MAX = max3(SETUP_CYC, STROBE_CYC, HOLD_CYC);
  localparam int unsigned PH_W   = $clog2(PH_MAX) + 1;
  localparam logic [N_SEL-1:0] SEL_ONE = N_SEL'(1);

  state_e            state;
  logic [PH_W-1:0]   phase;
  logic [ADR_W-1:0]  bus_adr;
  logic [DATA_W-1:0] bus_data;
  logic [N_SEL-1:0]  bus_sel;
  logic              bus_write;

  logic fifo_full;
  logic fifo_empty;
  logic fifo_push;
  logic fifo_pop;
  req_t req_in;
  req_t head;
  logic accept;
  logic sel_ok;

  // Request side
  assign bus.req_ready = !fifo_full;
  assign accept        = bus.req_valid && bus.req_ready;
  assign sel_ok        = 32'(bus.req_sel) < N_SEL;
  assign fifo_push     = accept && sel_ok;
  assign fifo_pop      = (state == IDLE) && !fifo_empty;

  always_comb begin
    req_in      = '0;
    req_in.sel  = bus.req_sel;
    req_in.adr  = bus.req_adr;
    req_in.data = bus.req_data;
  end

  synth_reg_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (OSC_CLK),
    .rst_n (iRST_N),
    .push  (fifo_push),
    .wdata (req_in),
    .pop   (fifo_pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge OSC_CLK or negedge iRST_N) begin
    if (!iRST_N) begin
      drop_cnt <= '0;
    end else if (accept && !sel_ok && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

  // Bus-cycle FSM. phase counts down the remaining cycles of the current state and is
  // reloaded on every state entry; adr/data are left as-is in IDLE.
  always_ff @(posedge OSC_CLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state     <= IDLE;
      phase     <= '0;
      bus_adr   <= '0;
      bus_data  <= '0;
      bus_sel   <= '0;
      bus_write <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!fifo_empty) begin
            bus_adr  <= head.adr;
            bus_data <= head.data;
            bus_sel  <= SEL_ONE << head.sel;
            phase    <= PH_W'(SETUP_CYC - 1);
            state    <= SETUP;
          end
        end
        SETUP: begin
          if (phase == '0) begin
            bus_write <= 1'b1;
            phase     <= PH_W'(STROBE_CYC - 1);
            state     <= STROBE;
          end else begin
            phase <= phase - 1'b1;
          end
        end
        STROBE: begin
          if (phase == '0) begin
            bus_write <= 1'b0;
            phase     <= PH_W'(HOLD_CYC - 1);
            state     <= HOLD;
          end else begin
            phase <= phase - 1'b1;
          end
        end
        HOLD: begin
          if (phase == '0) begin
            bus_sel <= '0;
            state   <= IDLE;
          end else begin
            phase <= phase - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.adr   = bus_adr;
  assign bus.data  = bus_data;
  assign bus.sel   = bus_sel;
  assign bus.write = bus_write;
  assign busy      = !fifo_empty || (state != IDLE);

`ifdef SYNTH_REG_SHADOW_EN
  // Mirror of every completed write, indexed {section, address}.
  logic [DATA_W-1:0] shadow_mem [N_SEL*128];
  logic [SEL_W-1:0]  shadow_sel;
  logic              shadow_we;

  assign shadow_we = (state == STROBE) && (phase == '0);

  always_ff @(posedge OSC_CLK or negedge iRST_N) begin
    if (!iRST_N) begin
      shadow_sel <= '0;
    end else if (fifo_pop) begin
      shadow_sel <= head.sel;
    end
  end

  // Read and write in the same cycle: the read sees the old contents.
  always_ff @(posedge OSC_CLK) begin
    if (shadow_we) shadow_mem[{shadow_sel, bus_adr}] <= bus_data;
    rd_data <= shadow_mem[{rd_sel, rd_adr}];
  end
`endif

endmodule

// File: tb/tb_synth_reg_writer.sv
// tb_synth_reg_writer: directed + random stimulus, checked against a transaction-level model
// (expected-transaction queue, queue occupancy, drop count, bus waveform timing).
module tb_synth_reg_writer;
  import synth_reg_pkg::*;

  localparam int unsigned FIFO_DEPTH = 8;
  localparam int unsigned N_SEL      = 3;
  localparam int unsigned SETUP_CYC  = 2;
  localparam int unsigned STROBE_CYC = 3;
  localparam int unsigned HOLD_CYC   = 2;
  localparam int unsigned TOTAL      = SETUP_CYC + STROBE_CYC + HOLD_CYC;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       busy;
  logic [7:0] drop_cnt;
`ifdef SYNTH_REG_SHADOW_EN
  logic [1:0] rd_sel = '0;
  logic [6:0] rd_adr = '0;
  logic [7:0] rd_data;
`endif

  synth_reg_writer_if #(.N_SEL(N_SEL)) bus ();

  always #5 clk = ~clk;

  synth_reg_writer #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .N_SEL      (N_SEL),
    .SETUP_CYC  (SETUP_CYC),
    .STROBE_CYC (STROBE_CYC),
    .HOLD_CYC   (HOLD_CYC)
  ) dut (
    .OSC_CLK  (clk),
    .iRST_N   (rst_n),
    .bus      (bus),
    .busy     (busy),
    .drop_cnt (drop_cnt)
`ifdef SYNTH_REG_SHADOW_EN
    ,
    .rd_sel   (rd_sel),
    .rd_adr   (rd_adr),
    .rd_data  (rd_data)
`endif
  );

  typedef struct {
    int unsigned sel;
    int unsigned adr;
    int unsigned data;
  } txn_t;

  txn_t        exp_q[$];
  txn_t        cur;
  int unsigned queued = 0;
  int unsigned drops = 0;
  int unsigned k = 0;
  bit          active = 1'b0;
  bit          expect_start = 1'b0;
  int          n_total = 0;
  int          n_pass = 0;
  int          n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Bus waveform model: each transaction occupies TOTAL samples with sel one-hot and adr/data
  // fixed, write high only in the strobe window, then one sample with sel back at zero.
  task automatic monitor();
    if (!active) begin
      check("tx_start", 32'(bus.sel != '0), 32'(expect_start));
      if (bus.sel != '0) begin
        if (exp_q.size() != 0) cur = exp_q.pop_front();
        if (queued != 0) queued--;
        active = 1'b1;
        k      = 0;
      end
    end
    if (active) begin
      if (k == TOTAL) begin
        check("sel_idle", 32'(bus.sel), 32'd0);
        check("write_idle", 32'(bus.write), 32'd0);
        active = 1'b0;
      end else begin
        check("sel", 32'(bus.sel), 32'd1 << cur.sel);
        check("adr", 32'(bus.adr), cur.adr);
        check("data", 32'(bus.data), cur.data);
        check("write", 32'(bus.write), 32'(k >= SETUP_CYC && k < SETUP_CYC + STROBE_CYC));
        k++;
      end
    end
  endtask

  // One clock: drive request, advance to the next negedge, update model, check status outputs.
  task automatic cycle(input bit v, input int unsigned s, input int unsigned a,
                       input int unsigned d, output bit acc);
    bus.req_valid = v;
    bus.req_sel   = 2'(s);
    bus.req_adr   = 7'(a);
    bus.req_data  = 8'(d);
    acc = v && rst_n && (queued < FIFO_DEPTH);
    @(negedge clk);
    monitor();
    if (acc) begin
      if (s < N_SEL) begin
        exp_q.push_back('{s, a, d});
        queued++;
      end else if (drops < 255) begin
        drops++;
      end
    end
    check("req_ready", 32'(bus.req_ready), 32'(queued < FIFO_DEPTH));
    check("busy", 32'(busy), 32'((queued != 0) || active));
    check("drop_cnt", 32'(drop_cnt), drops);
    expect_start = !active && (queued != 0);
  endtask

  task automatic idle(input int unsigned n);
    bit acc;
    for (int unsigned i = 0; i < n; i++) cycle(1'b0, 0, 0, 0, acc);
  endtask

  task automatic drain();
    bit acc;
    int unsigned n = 0;
    while ((queued != 0 || active) && n < 400) begin
      cycle(1'b0, 0, 0, 0, acc);
      n++;
    end
    check("drain_left", 32'(exp_q.size()) + 32'(active), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit          acc;
    bit          saw_not_ready;
    int unsigned n;
    int unsigned d;

    bus.req_valid = 1'b0;
    bus.req_sel   = '0;
    bus.req_adr   = '0;
    bus.req_data  = '0;

    // Reset state
    #1;
    check("rst_adr", 32'(bus.adr), 32'd0);
    check("rst_data", 32'(bus.data), 32'd0);
    check("rst_write", 32'(bus.write), 32'd0);
    check("rst_sel", 32'(bus.sel), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    check("rst_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Single write from idle: latency to write rise, then values kept in IDLE
    cycle(1'b1, SEL_OSC, 'h06, 'h40, acc);
    n = 0;
    while (bus.write !== 1'b1 && n < 20) begin
      cycle(1'b0, 0, 0, 0, acc);
      n++;
    end
    check("latency", n, 1 + SETUP_CYC);
    idle(TOTAL + 3);
    check("idle_adr_kept", 32'(bus.adr), 32'h06);
    check("idle_data_kept", 32'(bus.data), 32'h40);

    // Back-to-back requests, valid held until accepted; queue must fill
    saw_not_ready = 1'b0;
    for (int i = 0; i < 14; i++) begin
      d   = $urandom_range(0, 255);
      acc = 1'b0;
      n   = 0;
      while (!acc && n < 100) begin
        if (bus.req_ready === 1'b0) saw_not_ready = 1'b1;
        cycle(1'b1, i % N_SEL, 'h10 + i, d, acc);
        n++;
      end
    end
    bus.req_valid = 1'b0;
    check("full_seen", 32'(saw_not_ready), 32'd1);
    drain();

    // Random traffic, including out-of-range sections
    for (int i = 0; i < 500; i++) begin
      cycle(($urandom_range(0, 3) == 0), $urandom_range(0, 3), $urandom_range(0, 127),
            $urandom_range(0, 255), acc);
    end
    drain();

    // Reset clears drop count and everything else
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    queued = 0; drops = 0; active = 1'b0; expect_start = 1'b0; k = 0;
    check("rst2_drop", 32'(drop_cnt), 32'd0);
    idle(1);
    rst_n = 1'b1;
    idle(1);

    // Drops: first one, then saturation, with no bus activity
    cycle(1'b1, SEL_COM, 'h05, 'h55, acc);
    check("drop_one", 32'(drop_cnt), 32'd1);
    for (int i = 0; i < 256; i++) cycle(1'b1, SEL_COM, i % 128, i % 256, acc);
    idle(TOTAL + 2);
    check("drop_sat", 32'(drop_cnt), 32'd255);
    check("drop_no_bus", 32'(bus.sel), 32'd0);

    // Reset during STROBE with more entries queued
    cycle(1'b1, SEL_OSC, 'h21, 'h11, acc);
    cycle(1'b1, SEL_ENV, 'h22, 'h22, acc);
    cycle(1'b1, SEL_MAT, 'h23, 'h33, acc);
    bus.req_valid = 1'b0;
    n = 0;
    while (bus.write !== 1'b1 && n < 20) begin
      cycle(1'b0, 0, 0, 0, acc);
      n++;
    end
    check("strobe_reached", 32'(bus.write), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_write", 32'(bus.write), 32'd0);
    check("rst_mid_sel", 32'(bus.sel), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_ready", 32'(bus.req_ready), 32'd1);
    exp_q.delete();
    queued = 0; drops = 0; active = 1'b0; expect_start = 1'b0; k = 0;
    idle(2);
    rst_n = 1'b1;
    idle(3 * (TOTAL + 1) + 4);
    check("post_rst_busy", 32'(busy), 32'd0);

`ifdef SYNTH_REG_SHADOW_EN
    // Shadow RAM readback
    cycle(1'b1, SEL_ENV, 'h16, 'hA5, acc);
    drain();
    rd_sel = 2'd1;
    rd_adr = 7'h16;
    @(posedge clk);
    #1;
    check("shadow_rd", 32'(rd_data), 32'hA5);
    idle(1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
